// File: rtl/wb_write_arbiter_pkg.sv
// Shared register-file write definitions: default widths, the hardwired-zero index
// and the layout of one queued long-latency result.
package wb_write_arbiter_pkg;

   localparam int REG_DATA_W = 32;
   localparam int REG_ADDR_W = 5;
   localparam int REG_ZERO   = 0;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_result_queue.sv
// Ordered holding queue for long-latency results, with squash-by-address for
// entries overtaken by newer pipeline writes and two decode hazard lookups.
module wb_result_queue
   import wb_write_arbiter_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DEPTH  = 2,
   parameter int PTR_W  = $clog2(DEPTH),
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              push_valid,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   input  logic              squash_en,
   input  logic [ADDR_W-1:0] squash_addr,
   output logic              head_valid,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data,
   output logic [CNT_W-1:0]  count,
   input  logic [ADDR_W-1:0] chk_addr1,
   input  logic [ADDR_W-1:0] chk_addr2,
   output logic              chk_hit1,
   output logic              chk_hit2
);

   logic [DEPTH-1:0]  valid_q;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;

   // A push never targets the head slot while it pops, since the arbiter stops
   // accepting at full; squash, pop and push therefore touch distinct state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (squash_en && valid_q[i] && (addr_q[i] == squash_addr))
               valid_q[i] <= 1'b0;
         end
         if (pop) begin
            valid_q[head] <= 1'b0;
            head          <= head + PTR_W'(1);
         end
         if (push) begin
            valid_q[tail] <= push_valid;
            addr_q[tail]  <= push_addr;
            data_q[tail]  <= push_data;
            tail          <= tail + PTR_W'(1);
         end
         if (push && !pop)
            count <= count + CNT_W'(1);
         else if (!push && pop)
            count <= count - CNT_W'(1);
      end
   end

   assign head_valid = valid_q[head];
   assign head_addr  = addr_q[head];
   assign head_data  = data_q[head];

   always_comb begin
      chk_hit1 = 1'b0;
      chk_hit2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (addr_q[i] == chk_addr1)) chk_hit1 = 1'b1;
         if (valid_q[i] && (addr_q[i] == chk_addr2)) chk_hit2 = 1'b1;
      end
      if (chk_addr1 == ADDR_W'(REG_ZERO)) chk_hit1 = 1'b0;
      if (chk_addr2 == ADDR_W'(REG_ZERO)) chk_hit2 = 1'b0;
   end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: pipeline writes win, long-latency results
// bypass when the queue is empty or wait in order behind it.
module wb_write_arbiter
   import wb_write_arbiter_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DEPTH  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pipe_we,
   input  logic [ADDR_W-1:0]        pipe_addr,
   input  logic [DATA_W-1:0]        pipe_data,
   input  logic                     lu_valid,
   output logic                     lu_ready,
   input  logic [ADDR_W-1:0]        lu_addr,
   input  logic [DATA_W-1:0]        lu_data,
   output logic                     rf_we,
   output logic [ADDR_W-1:0]        rf_addr,
   output logic [DATA_W-1:0]        rf_data,
   input  logic [ADDR_W-1:0]        chk_addr1,
   input  logic [ADDR_W-1:0]        chk_addr2,
   output logic                     chk_hit1,
   output logic                     chk_hit2,
   output logic [$clog2(DEPTH):0]   q_count
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              pipe_act;
   logic              lu_acc;
   logic              lu_nonzero;
   logic              q_empty;
   logic              head_valid;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic              head_wr;
   logic              bypass;
   logic              pop;
   logic              push;
   logic              push_valid;

   assign pipe_act   = pipe_we && (pipe_addr != ADDR_W'(REG_ZERO));
   assign lu_ready   = (q_count < CNT_W'(DEPTH));
   assign lu_acc     = lu_valid && lu_ready;
   assign lu_nonzero = (lu_addr != ADDR_W'(REG_ZERO));
   assign q_empty    = (q_count == '0);

   assign head_wr    = !pipe_act && !q_empty && head_valid;
   assign bypass     = !pipe_act && q_empty && lu_acc && lu_nonzero;
   // Invalid heads drain regardless of the pipe so squashed slots never block.
   assign pop        = !q_empty && (head_wr || !head_valid);
   assign push       = lu_acc && lu_nonzero && !bypass;
   assign push_valid = !(pipe_act && (pipe_addr == lu_addr));

   always_comb begin
      rf_we   = 1'b0;
      rf_addr = pipe_addr;
      rf_data = pipe_data;
      if (pipe_act) begin
         rf_we = 1'b1;
      end else if (head_wr) begin
         rf_we   = 1'b1;
         rf_addr = head_addr;
         rf_data = head_data;
      end else if (bypass) begin
         rf_we   = 1'b1;
         rf_addr = lu_addr;
         rf_data = lu_data;
      end
   end

   wb_result_queue #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .push_valid  (push_valid),
      .push_addr   (lu_addr),
      .push_data   (lu_data),
      .pop         (pop),
      .squash_en   (pipe_act),
      .squash_addr (pipe_addr),
      .head_valid  (head_valid),
      .head_addr   (head_addr),
      .head_data   (head_data),
      .count       (q_count),
      .chk_addr1   (chk_addr1),
      .chk_addr2   (chk_addr2),
      .chk_hit1    (chk_hit1),
      .chk_hit2    (chk_hit2)
   );

endmodule
